// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronized, four-state debouncer for an active-low key with press/release strobes.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to add the long-press hold counter and long_pulse strobe.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);
  typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;
  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);
  state_t r_state, w_next;
  logic [1:0] r_sync;
  logic [23:0] r_cnt, w_cnt;
  logic w_s_key_n, w_db_done, w_debouncing, w_level, w_press, w_release, w_long;
  assign w_s_key_n = r_sync[1];
  assign w_db_done = r_cnt == DB_LAST;
  assign w_debouncing = r_state == DB_PRESS || r_state == DB_RELEASE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_state <= IDLE;
      r_cnt <= '0;
      {key_level, press_pulse, release_pulse, long_pulse} <= '0;
    end else begin
      r_sync <= {r_sync[0], key_n};
      r_state <= w_next;
      r_cnt <= w_cnt;
      {key_level, press_pulse, release_pulse, long_pulse} <= {w_level, w_press, w_release, w_long};
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = w_s_key_n ? IDLE : DB_PRESS;
      DB_PRESS:   w_next = w_s_key_n ? IDLE : (w_db_done ? HELD : DB_PRESS);
      HELD:       w_next = w_s_key_n ? DB_RELEASE : HELD;
      DB_RELEASE: w_next = !w_s_key_n ? HELD : (w_db_done ? IDLE : DB_RELEASE);
      default:    w_next = IDLE;
    endcase
  end
  always_comb begin
    w_press = r_state == DB_PRESS && w_next == HELD;
    w_release = r_state == DB_RELEASE && w_next == IDLE;
    w_level = w_next == HELD || w_next == DB_RELEASE;
    // counter restarts on any state change and saturates at the accept value
    w_cnt = (w_next != r_state || !w_debouncing) ? '0 : r_cnt + {23'd0, !w_db_done};
  end
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam logic [25:0] LONG_LAST = 26'(LONG_CYCLES - 1);
  localparam logic [25:0] LONG_SAT = 26'(LONG_CYCLES);
  logic [25:0] r_hold;
  logic w_holding;
  assign w_holding = r_state == HELD || r_state == DB_RELEASE;
  assign w_long = w_holding && r_hold == LONG_LAST;
  // parks one past the fire value so the strobe cannot repeat until the next press
  always_ff @(posedge clk) begin
    if (rst) r_hold <= '0;
    else if (w_press) r_hold <= '0;
    else if (w_holding && r_hold != LONG_SAT) r_hold <= r_hold + 26'd1;
  end
`else
  // LONG_CYCLES is always >= 1, so this is a constant 0
  assign w_long = LONG_CYCLES < 1;
`endif
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed stimulus with a time-stamped pulse scoreboard checked by a negedge monitor.
module tb_key_debounce;
  localparam int D = 4, L = 10;
  localparam logic [2:0] P = 3'b100, R = 3'b010, LG = 3'b001;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  typedef struct {int cyc; logic [2:0] kind;} exp_t;
  logic clk = 1'b0, rst = 1'b1, key_n = 1'b1;
  logic key_level, press_pulse, release_pulse, long_pulse;
  int cyc = 0, n_chk = 0, n_fail = 0;
  exp_t q[$];
  key_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .key_level(key_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    logic [2:0] k;
    int ec;
    logic [2:0] ek;
    k = {press_pulse, release_pulse, long_pulse};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_chk++;
      n_fail++;
      $display("FAIL missed_pulse: kind=%b due after edge %0d, still absent at edge %0d", q[0].kind, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (k != 3'b000) begin
      n_chk++;
      ec = q.size() > 0 ? q[0].cyc : -1;
      ek = q.size() > 0 ? q[0].kind : 3'b000;
      if (ec != cyc || ek != k) begin
        n_fail++;
        $display("FAIL pulse: got kind=%b after edge %0d, expected kind=%b after edge %0d", k, cyc, ek, ec);
      end
      if (ec == cyc) void'(q.pop_front());
    end
  end
  task automatic goto(int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic exp_at(int t, logic [2:0] k);
    q.push_back('{t, k});
  endtask
  task automatic chk_lvl(int t, logic v, string nm);
    goto(t);
    n_chk++;
    if (key_level !== v) begin
      n_fail++;
      $display("FAIL %s: key_level=%b after edge %0d, expected %b", nm, key_level, cyc, v);
    end
  endtask
  task automatic chk_clear(string nm);
    n_chk++;
    if ({key_level, press_pulse, release_pulse, long_pulse} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s: outputs=%b, expected 0000", nm, {key_level, press_pulse, release_pulse, long_pulse});
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int e;
    repeat (2) @(negedge clk);
    chk_clear("reset_state");
    rst = 1'b0;
    @(negedge clk);
    // clean press, one long pulse, then release
    e = cyc + 1;
    key_n = 1'b0;
    exp_at(e + 6, P);
    if (LONG_EN) exp_at(e + 16, LG);
    chk_lvl(e + 5, 1'b0, "clean_before_accept");
    chk_lvl(e + 6, 1'b1, "clean_accept");
    chk_lvl(e + 25, 1'b1, "long_hold");
    goto(e + 29);
    e = cyc + 1;
    key_n = 1'b1;
    exp_at(e + 6, R);
    chk_lvl(e + 5, 1'b1, "release_before_accept");
    chk_lvl(e + 6, 1'b0, "release_accept");
    goto(e + 10);
    // bounce: low for three sampling edges only
    e = cyc + 1;
    key_n = 1'b0;
    goto(e + 2);
    key_n = 1'b1;
    chk_lvl(e + 4, 1'b0, "bounce_mid");
    chk_lvl(e + 8, 1'b0, "bounce_after");
    goto(e + 12);
    // release glitch while held, then a real release
    e = cyc + 1;
    key_n = 1'b0;
    exp_at(e + 6, P);
    if (LONG_EN) exp_at(e + 16, LG);
    exp_at(e + 18, R);
    goto(e + 7);
    key_n = 1'b1;
    goto(e + 9);
    key_n = 1'b0;
    chk_lvl(e + 11, 1'b1, "glitch_during");
    goto(e + 11);
    key_n = 1'b1;
    chk_lvl(e + 14, 1'b1, "glitch_after");
    chk_lvl(e + 17, 1'b1, "glitch_release_pending");
    chk_lvl(e + 18, 1'b0, "glitch_release_accept");
    goto(e + 24);
    // reset mid-hold with key kept low
    e = cyc + 1;
    key_n = 1'b0;
    exp_at(e + 6, P);
    exp_at(e + 18, P);
    if (LONG_EN) exp_at(e + 28, LG);
    goto(e + 10);
    rst = 1'b1;
    goto(e + 11);
    chk_clear("reset_mid_hold");
    rst = 1'b0;
    chk_lvl(e + 17, 1'b0, "rehold_before_accept");
    chk_lvl(e + 18, 1'b1, "rehold_accept");
    goto(e + 34);
    e = cyc + 1;
    key_n = 1'b1;
    exp_at(e + 6, R);
    chk_lvl(e + 6, 1'b0, "rehold_release");
    goto(e + 12);
    while (q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL pending_pulse: kind=%b due after edge %0d never seen", q[0].kind, q[0].cyc);
      void'(q.pop_front());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the number of stable cycles needed to accept an edge (20 ms at 50 MHz), legal range 1..2^24-1.
REQ-002 The block SHALL have parameter LONG_CYCLES, default 50_000_000, meaning the number of held cycles needed to report a long press (1 s at 50 MHz), legal range 1..2^26-1.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port key_n, input, 1 bit, the raw asynchronous board key, active-low (0 = pressed).
REQ-006 The block SHALL have port key_level, output, 1 bit, the debounced key state (1 = pressed).
REQ-007 The block SHALL have port press_pulse, output, 1 bit, a one-cycle strobe on each accepted press.
REQ-008 The block SHALL have port release_pulse, output, 1 bit, a one-cycle strobe on each accepted release.
REQ-009 The block SHALL have port long_pulse, output, 1 bit, a one-cycle strobe when a press has been held for LONG_CYCLES.

Function
REQ-010 key_n SHALL pass through a 2-flop synchronizer; the FSM SHALL see only the synchronized value s_key_n.
REQ-011 The FSM SHALL have exactly four states: IDLE (released), DB_PRESS, HELD and DB_RELEASE.
REQ-012 In IDLE with s_key_n=0, the FSM SHALL go to DB_PRESS and clear the debounce counter.
REQ-013 In DB_PRESS with s_key_n=1, the FSM SHALL return to IDLE (bounce rejected) with no pulse.
REQ-014 In DB_PRESS with s_key_n=0 and cnt==DEBOUNCE_CYCLES-1, the FSM SHALL go to HELD, set key_level=1 and press_pulse=1 for one cycle; otherwise cnt SHALL increment.
REQ-015 In HELD with s_key_n=1, the FSM SHALL go to DB_RELEASE and clear cnt.
REQ-016 In DB_RELEASE with s_key_n=0, the FSM SHALL return to HELD with no pulse.
REQ-017 In DB_RELEASE with s_key_n=1 and cnt==DEBOUNCE_CYCLES-1, the FSM SHALL go to IDLE, set key_level=0 and release_pulse=1 for one cycle.
REQ-018 Latency: with key_n held low from the first sampling edge E, press_pulse SHALL be high in the cycle after edge E+DEBOUNCE_CYCLES+2; release SHALL be symmetric.
REQ-019 All outputs SHALL be registered, and the three pulses SHALL never be high for more than one consecutive cycle.
REQ-020 The debounce counter SHALL be 24 bits wide, SHALL never wrap, and SHALL be cleared on every state entry.

Reset
REQ-021 With rst=1 at a rising edge, the block SHALL set state to IDLE, counters to 0, synchronizer flops to 1, and key_level, press_pulse, release_pulse and long_pulse to 0.
REQ-022 A reset mid-press SHALL discard the press with no release_pulse; a key still held after reset SHALL be re-debounced from IDLE and yield a fresh press_pulse.
REQ-023 rst SHALL take priority over every FSM transition in the same cycle.

Configuration
REQ-024 With macro KEY_DEBOUNCE_LONG_PRESS_EN defined, a 26-bit hold counter SHALL clear on entry to HELD from DB_PRESS and increment in HELD and DB_RELEASE.
REQ-025 With KEY_DEBOUNCE_LONG_PRESS_EN defined, long_pulse SHALL fire once when the hold counter equals LONG_CYCLES-1, after which the hold counter SHALL saturate and not re-fire until the next accepted press.
REQ-026 With KEY_DEBOUNCE_LONG_PRESS_EN undefined, the hold counter SHALL be absent and long_pulse SHALL be tied to 0.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, macro defined)
REQ-027 Clean press: key_n 1->0 first sampled at edge 1 and held SHALL give press_pulse high only after edge 7 and key_level=1 from edge 7.
REQ-028 Bounce: key_n low for 3 edges then high SHALL return the FSM to IDLE, with press_pulse=0 and key_level=0 throughout.
REQ-029 Long press: key_n held low SHALL give press_pulse after edge 7 and exactly one long_pulse after edge 17, with none thereafter while held.
REQ-030 Release glitch: while HELD, key_n high for 2 cycles then low SHALL give release_pulse=0 and key_level=1; key_n then held high SHALL give release_pulse 7 edges after the rise.
REQ-031 Reset mid-hold: rst=1 for one cycle at edge 12 with key_n low SHALL clear all outputs at edge 12, produce no release_pulse, and give a new press_pulse after edge 19.
REQ-032 Macro undefined: the REQ-029 stimulus SHALL give long_pulse=0 throughout, with press/release timing unchanged.
